// File: rtl/mac_accum_scheduler_if.sv
// Handshake bundle between the MAC column scheduler and its neighbours.
//   in_valid/in_ready : operand beat into the adder tree
//   tree_en           : advance enable for every tree pipeline register
//   tree_sum          : signed adder-tree output
//   out_valid/out_ready/out_data : signed accumulated result to writeback
// slave  : the scheduler side
// master : the environment side (operand source, tree, writeback)
interface mac_accum_scheduler_if #(
  parameter int SUM_W = 20,
  parameter int ACC_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             tree_en;
  logic [SUM_W-1:0] tree_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport slave (
    input  in_valid, tree_sum, out_ready,
    output in_ready, tree_en, out_valid, out_data
  );

  modport master (
    output in_valid, tree_sum, out_ready,
    input  in_ready, tree_en, out_valid, out_data
  );
endinterface

// File: rtl/mac_accum_scheduler.sv
// MAC column scheduler: issues operand beats into the pipelined adder tree,
// tracks in-flight beats with a valid pipe matched to the tree latency,
// accumulates cfg_len tree sums per output and emits cfg_num signed
// (optionally ReLU'd) results per job. Output backpressure freezes the tree.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start, cfg_len/num/relu : job launch and configuration (IDLE only)
//   busy, done            : job status, done pulses on return to IDLE
//   bus (slave)           : beat input, tree control/result, result output
module mac_accum_scheduler #(
  parameter int PIPE_DEPTH = 3,
  parameter int SUM_W      = 20,
  parameter int ACC_W      = 32,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_num,
  input  logic             cfg_relu,
  output logic             busy,
  output logic             done,
  mac_accum_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 r_state, w_nxt;
  logic [CNT_W-1:0]       r_len, r_num, r_beat, r_out_cnt;
  logic                   r_relu;
  logic [2*CNT_W-1:0]     r_total, r_issued;
  logic [PIPE_DEPTH-1:0]  r_vld_pipe;
  logic [ACC_W-1:0]       r_acc, r_out_data;
  logic                   r_out_valid, r_done;

  logic                   w_stall, w_in_ready, w_start_ok, w_accept;
  logic                   w_fire, w_last;
  logic [ACC_W-1:0]       w_sext, w_acc_nxt, w_res;

  // Backpressure: a held result that is not taken freezes everything.
  assign w_stall = r_out_valid & ~bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_in_ready = 1'b0;
    w_start_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && cfg_len != '0 && cfg_num != '0) begin
          w_start_ok = 1'b1;
          w_nxt      = S_RUN;
        end
      end
      S_RUN: begin
        w_in_ready = ~w_stall & (r_issued < r_total);
        if (w_in_ready && bus.in_valid && r_issued == r_total - 1'b1)
          w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave only once the last result is loaded and being (or already) taken.
        if (r_vld_pipe == '0 && (!r_out_valid || bus.out_ready) && r_out_cnt == r_num)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_accept  = w_in_ready & bus.in_valid;
  assign w_fire    = r_vld_pipe[PIPE_DEPTH-1] & ~w_stall;
  assign w_last    = (r_beat == r_len - 1'b1);
  assign w_sext    = {{(ACC_W-SUM_W){bus.tree_sum[SUM_W-1]}}, bus.tree_sum};
  assign w_acc_nxt = (r_beat == '0) ? w_sext : r_acc + w_sext;
  assign w_res     = (r_relu && w_acc_nxt[ACC_W-1]) ? '0 : w_acc_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len       <= '0;
      r_num       <= '0;
      r_relu      <= 1'b0;
      r_total     <= '0;
      r_issued    <= '0;
      r_beat      <= '0;
      r_out_cnt   <= '0;
      r_vld_pipe  <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && (w_nxt == S_IDLE);
      if (w_start_ok) begin
        r_len     <= cfg_len;
        r_num     <= cfg_num;
        r_relu    <= cfg_relu;
        r_total   <= {{CNT_W{1'b0}}, cfg_len} * {{CNT_W{1'b0}}, cfg_num};
        r_issued  <= '0;
        r_beat    <= '0;
        r_out_cnt <= '0;
      end
      // The valid pipe mirrors the tree registers, so it moves only with tree_en.
      if (!w_stall) begin
        for (int i = PIPE_DEPTH-1; i > 0; i--) r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_vld_pipe[0] <= w_accept;
      end
      if (w_accept) r_issued <= r_issued + 1'b1;
      if (w_fire) begin
        r_acc <= w_acc_nxt;
        if (w_last) begin
          r_beat    <= '0;
          r_out_cnt <= r_out_cnt + 1'b1;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      // A fire implies no stall, so a new load may replace a result being taken.
      if (w_fire && w_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign bus.in_ready  = w_in_ready;
  // Tree is idle outside a job; gating keeps all outputs 0 in reset.
  assign bus.tree_en   = (r_state != S_IDLE) & ~w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_mac_accum_scheduler.sv
// Self-checking bench for mac_accum_scheduler: directed job table, hand-built
// stall/restart/reset sequences and randomized jobs against a job-level model.
module tb_mac_accum_scheduler;
  localparam int P     = 3;
  localparam int SUM_W = 20;
  localparam int ACC_W = 32;
  localparam int CNT_W = 8;
  localparam logic signed [SUM_W-1:0] JUNK = 20'sh7BEEF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0, cfg_num = '0;
  logic cfg_relu = 1'b0;
  logic busy, done;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;

  mac_accum_scheduler_if #(.SUM_W(SUM_W), .ACC_W(ACC_W)) bus ();

  mac_accum_scheduler #(.PIPE_DEPTH(P), .SUM_W(SUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_len(cfg_len), .cfg_num(cfg_num),
    .cfg_relu(cfg_relu), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in adder tree: a value issued with tree_en appears after P advances.
  logic signed [SUM_W-1:0] beat_data = '0;
  logic signed [SUM_W-1:0] tp [P];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < P; i++) tp[i] <= JUNK;
    end else if (bus.tree_en) begin
      for (int i = P-1; i > 0; i--) tp[i] <= tp[i-1];
      tp[0] <= (bus.in_valid && bus.in_ready) ? beat_data : JUNK;
    end
  end
  assign bus.tree_sum = tp[P-1];

  typedef struct {
    int len, num;
    bit relu;
    int sums [6];
    int exp  [3];
  } vec_t;
  vec_t tbl [5];

  int src [$];
  int q_beats [$];
  int q_out [$];

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic set_vec(input int i, input int len, input int num, input bit relu,
                         input int s0, input int s1, input int s2, input int s3, input int s4,
                         input int s5, input int e0, input int e1, input int e2);
    tbl[i].len = len; tbl[i].num = num; tbl[i].relu = relu;
    tbl[i].sums[0] = s0; tbl[i].sums[1] = s1; tbl[i].sums[2] = s2;
    tbl[i].sums[3] = s3; tbl[i].sums[4] = s4; tbl[i].sums[5] = s5;
    tbl[i].exp[0] = e0; tbl[i].exp[1] = e1; tbl[i].exp[2] = e2;
  endtask

  function automatic int rnd_sum();
    logic [SUM_W-1:0] r;
    r = SUM_W'($urandom);
    return int'($signed(r));
  endfunction

  // Result k of a job: sum of its len consecutive issued sums, 32-bit wrap, optional ReLU.
  function automatic int model(input int k, input int len, input bit relu);
    int s = 0;
    for (int j = 0; j < len; j++) s += src[k*len + j];
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  function automatic logic signed [SUM_W-1:0] next_beat();
    int idx = q_beats.size();
    if (idx < src.size()) return SUM_W'(src[idx]);
    return JUNK;
  endfunction

  // tix>=0 takes sums/expectations from the table, else random sums and the model.
  task automatic run_job(input int tix, input int len, input int num, input bit relu,
                         input int gap, input int stl, input int hold, input int restart);
    int first_acc = -1, first_ov = -1, last_hs = -1, done_cyc = -1, n_done = 0, it = 0, e;
    logic signed [ACC_W-1:0] held;
    bit held_done = 0;
    q_beats.delete(); q_out.delete(); src.delete();
    for (int i = 0; i < len*num; i++) src.push_back(tix >= 0 ? tbl[tix].sums[i] : rnd_sum());
    while (n_done == 0 && it < 3000) begin
      @(negedge clk);
      if (hold > 0 && !held_done && bus.out_valid) begin
        held = bus.out_data;
        held_done = 1;
        for (int h = 0; h < hold; h++) begin
          start = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b1; beat_data = next_beat();
          #1;
          chk("hold_tree_en", bus.tree_en, 0);
          chk("hold_in_ready", bus.in_ready, 0);
          chk("hold_out_valid", bus.out_valid, 1);
          chk("hold_out_data", bus.out_data, held);
          @(negedge clk);
        end
      end
      start    = (it == 0) || (it == restart);
      cfg_len  = (it == 0) ? CNT_W'(len) : 8'd1;
      cfg_num  = (it == 0) ? CNT_W'(num) : 8'd1;
      cfg_relu = (it == 0) ? relu : !relu;
      bus.in_valid  = ($urandom_range(99) >= gap);
      beat_data     = next_beat();
      bus.out_ready = ($urandom_range(99) >= stl);
      #1;
      if (it == 1) chk("busy_in_job", busy, 1);
      if (bus.in_valid && bus.in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        q_beats.push_back(int'(beat_data));
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.out_valid && bus.out_ready) begin
        q_out.push_back(int'($signed(bus.out_data)));
        last_hs = cyc;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      it++;
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("job_done_seen", n_done, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (done) n_done++;
    end
    chk("done_count", n_done, 1);
    chk("busy_after_done", busy, 0);
    chk("beats_accepted", q_beats.size(), len*num);
    chk("results_count", q_out.size(), num);
    for (int k = 0; k < num && k < q_out.size(); k++) begin
      e = (tix >= 0) ? tbl[tix].exp[k] : model(k, len, relu);
      chk($sformatf("result[%0d]", k), q_out[k], e);
    end
    if (tix >= 0) begin
      chk("first_result_latency", first_ov - first_acc - 1, P + len - 1);
      chk("done_after_last_hs", done_cyc - last_hs, 1);
    end
  endtask

  task automatic bad_start(input int len, input int num);
    int nd = 0;
    @(negedge clk);
    start = 1'b1; cfg_len = CNT_W'(len); cfg_num = CNT_W'(num);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = 1'b0; #1;
      if (done) nd++;
    end
    chk($sformatf("bad_start_busy_%0d_%0d", len, num), busy, 0);
    chk($sformatf("bad_start_done_%0d_%0d", len, num), nd, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_vec(0, 3, 2, 0, 5, -2, 7, 100, 1, -1, 10, 100, 0);
    set_vec(1, 2, 1, 1, -8, 3, 0, 0, 0, 0, 0, 0, 0);
    set_vec(2, 2, 1, 0, -8, 3, 0, 0, 0, 0, -5, 0, 0);
    set_vec(3, 1, 3, 1, -4, 9, 0, 0, 0, 0, 0, 9, 0);
    set_vec(4, 6, 1, 0, 524287, 524287, -524288, 1, 2, 3, 524292, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_tree_en", bus.tree_en, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_job(i, tbl[i].len, tbl[i].num, tbl[i].relu, 0, 0, 0, -1);

    // Six cycles of backpressure on a held result, then release.
    run_job(-1, 2, 3, 0, 0, 0, 6, -1);
    // Start pulsed mid-RUN with a different config must be ignored.
    run_job(0, 3, 2, 0, 0, 0, 0, 3);
    // Length-1 job with input gaps: each tree sum is a result.
    run_job(-1, 1, 4, 0, 50, 0, 0, -1);

    bad_start(3, 0);
    bad_start(0, 2);

    // Asynchronous reset in the middle of a job with a result held.
    @(negedge clk);
    start = 1'b1; cfg_len = 8'd1; cfg_num = 8'd8; cfg_relu = 1'b0;
    bus.in_valid = 1'b1; beat_data = 20'sd77; bus.out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_in_ready", bus.in_ready, 0);
    chk("midreset_tree_en", bus.tree_en, 0);
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_out_data", bus.out_data, 0);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; reset_n = 1'b1;
    run_job(-1, 3, 2, 0, 0, 0, 0, -1);

    for (int j = 0; j < 12; j++)
      run_job(-1, $urandom_range(5, 1), $urandom_range(4, 1), 1'($urandom_range(1)), 30, 30, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
